// File: rtl/wb_scoreboard_pkg.sv
// Shared types for the writeback scoreboard: FSM states, failure codes
// and the expected-writeback entry carried through the FIFO.
package wb_scoreboard_pkg;

  localparam int XLEN = 32;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RUN   = 3'd1,
    DRAIN = 3'd2,
    PASS  = 3'd3,
    FAIL  = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    FC_NONE       = 2'd0,
    FC_MISMATCH   = 2'd1,
    FC_UNEXPECTED = 2'd2,
    FC_TIMEOUT    = 2'd3
  } fail_code_e;

  typedef struct packed {
    logic [4:0]      a;
    logic [XLEN-1:0] d;
  } exp_entry_t;

endpackage

// File: rtl/wb_scoreboard_if.sv
// Expected-entry push channel and pipeline writeback channel.
// master = stimulus/pipeline side, slave = scoreboard.
interface wb_scoreboard_if #(
  parameter int XLEN = 32
);
  logic            exp_valid;
  logic            exp_ready;
  logic [4:0]      exp_a;
  logic [XLEN-1:0] exp_d;
  logic            wb_e;
  logic [4:0]      wb_a;
  logic [XLEN-1:0] wb_d;

  modport master (
    output exp_valid, exp_a, exp_d, wb_e, wb_a, wb_d,
    input  exp_ready
  );

  modport slave (
    input  exp_valid, exp_a, exp_d, wb_e, wb_a, wb_d,
    output exp_ready
  );
endinterface

// File: rtl/wb_scoreboard_sb_fifo.sv
// sb_fifo: synchronous FIFO with a registered occupancy count.
// Pointers wrap modulo DEPTH (power of two); full/empty decode the count.
// Push while full and pop while empty are dropped.
module sb_fifo #(
  parameter int  DEPTH = 16,
  parameter type T     = logic [7:0]
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  T     push_data,
  input  logic pop,
  output logic full,
  output logic empty,
  output T     head
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  T              mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] cnt;

  logic do_push;
  logic do_pop;

  assign full    = (cnt == CW'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Storage write; no reset needed since reads are gated by the count.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end
endmodule

// File: rtl/wb_scoreboard.sv
// wb_scoreboard: in-order writeback checker with watchdog and
// end-of-program drain. Expected (rd, value) pairs are queued by the
// stimulus side and popped by each qualified pipeline writeback.
// Optional macro WB_SCOREBOARD_SHADOW_EN adds a mirror register file
// output (shadow_regs) written on every qualified writeback.
module wb_scoreboard #(
  parameter int XLEN         = 32,
  parameter int DEPTH        = 16,
  parameter int TIMEOUT      = 64,
  parameter int DRAIN_CYCLES = 8,
  parameter int STOP_ON_ERR  = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [XLEN-1:0]      pc_end,
  input  logic [XLEN-1:0]      pc_out,
  wb_scoreboard_if.slave       bus,
  output logic                 busy,
  output logic                 pass,
  output logic                 fail,
  output logic [1:0]           fail_code,
  output logic [15:0]          match_cnt,
  output logic [15:0]          mismatch_cnt,
  output logic [4:0]           first_err_a,
  output logic [XLEN-1:0]      first_err_d,
  output logic [XLEN-1:0]      first_err_exp
`ifdef WB_SCOREBOARD_SHADOW_EN
  , output logic [31:0][XLEN-1:0] shadow_regs
`endif
);
  import wb_scoreboard_pkg::*;

  localparam int WW = $clog2(TIMEOUT + 1);
  localparam int DW = $clog2(DRAIN_CYCLES + 1);

  state_e          state;
  logic [XLEN-1:0] pc_end_q;
  logic [WW-1:0]   wdog;
  logic [DW-1:0]   drain_cnt;

  logic       fifo_full;
  logic       fifo_empty;
  exp_entry_t head;
  exp_entry_t push_data;

  logic       push;
  logic       qual;
  logic       pop;
  logic       is_match;
  logic       is_err;
  logic       stop_err;
  logic       err_seen;
  fail_code_e err_code;

  // Pushes are only accepted before the program has reached its end.
  assign bus.exp_ready = !fifo_full && (state == IDLE || state == RUN);
  assign push          = bus.exp_valid && bus.exp_ready;
  assign push_data     = '{a: bus.exp_a, d: bus.exp_d};

  // Only non-x0 writebacks while checking are compared against the queue.
  assign qual     = bus.wb_e && (bus.wb_a != 5'd0) && (state == RUN || state == DRAIN);
  assign pop      = qual && !fifo_empty;
  assign is_match = pop && (head.a == bus.wb_a) && (head.d == bus.wb_d);
  assign is_err   = qual && !is_match;
  assign err_code = fifo_empty ? FC_UNEXPECTED : FC_MISMATCH;
  assign stop_err = is_err && (STOP_ON_ERR != 0);
  assign err_seen = (fail_code != FC_NONE);

  // A same-cycle push into an empty FIFO is not visible to the writeback.
  sb_fifo #(
    .DEPTH (DEPTH),
    .T     (exp_entry_t)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (head)
  );

  // Scoreboard FSM, counters and first-error capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      busy          <= 1'b0;
      pass          <= 1'b0;
      fail          <= 1'b0;
      fail_code     <= FC_NONE;
      match_cnt     <= '0;
      mismatch_cnt  <= '0;
      first_err_a   <= '0;
      first_err_d   <= '0;
      first_err_exp <= '0;
      pc_end_q      <= '0;
      wdog          <= '0;
      drain_cnt     <= '0;
    end else begin
      if (is_match && match_cnt != 16'hFFFF)   match_cnt    <= match_cnt + 16'd1;
      if (is_err && mismatch_cnt != 16'hFFFF)  mismatch_cnt <= mismatch_cnt + 16'd1;

      if (is_err && !err_seen) begin
        first_err_a   <= bus.wb_a;
        first_err_d   <= bus.wb_d;
        first_err_exp <= fifo_empty ? '0 : head.d;
        fail_code     <= err_code;
      end

      case (state)
        IDLE: begin
          if (start) begin
            state    <= RUN;
            busy     <= 1'b1;
            pc_end_q <= pc_end;
            wdog     <= '0;
          end
        end
        RUN: begin
          wdog <= qual ? '0 : wdog + 1'b1;
          if (stop_err) begin
            state <= FAIL;
            busy  <= 1'b0;
            fail  <= 1'b1;
          end else if (!qual && wdog == WW'(TIMEOUT - 1)) begin
            state <= FAIL;
            busy  <= 1'b0;
            fail  <= 1'b1;
            if (!err_seen && !is_err) fail_code <= FC_TIMEOUT;
          end else if (pc_out >= pc_end_q) begin
            state     <= DRAIN;
            drain_cnt <= '0;
          end
        end
        DRAIN: begin
          drain_cnt <= drain_cnt + 1'b1;
          if (stop_err) begin
            state <= FAIL;
            busy  <= 1'b0;
            fail  <= 1'b1;
          end else if (fifo_empty) begin
            busy <= 1'b0;
            if (mismatch_cnt == '0 && !is_err) begin
              state <= PASS;
              pass  <= 1'b1;
            end else begin
              state <= FAIL;
              fail  <= 1'b1;
            end
          end else if (drain_cnt == DW'(DRAIN_CYCLES - 1)) begin
            state <= FAIL;
            busy  <= 1'b0;
            fail  <= 1'b1;
            if (!err_seen && !is_err) fail_code <= FC_TIMEOUT;
          end
        end
        default: ; // PASS / FAIL hold until reset
      endcase
    end
  end

`ifdef WB_SCOREBOARD_SHADOW_EN
  // Mirror register file; x0 is never written because qual excludes it.
  always_ff @(posedge clk) begin
    if (reset)     shadow_regs <= '0;
    else if (qual) shadow_regs[bus.wb_a] <= bus.wb_d;
  end
`endif

endmodule

// File: tb/tb_wb_scoreboard.sv
// Directed bench for wb_scoreboard: match, mismatch, unexpected/x0,
// no-bypass, timeout, full/wrap and reset-mid-run scenarios.
module tb_wb_scoreboard;
  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] pc_end;
  logic [31:0] pc_out;
  logic        busy, pass, fail;
  logic [1:0]  fail_code;
  logic [15:0] match_cnt, mismatch_cnt;
  logic [4:0]  first_err_a;
  logic [31:0] first_err_d, first_err_exp;
`ifdef WB_SCOREBOARD_SHADOW_EN
  logic [31:0][31:0] shadow_regs;
`endif

  int vectors = 0;
  int miscompares = 0;

  wb_scoreboard_if #(.XLEN(32)) bus ();

  wb_scoreboard dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .pc_end        (pc_end),
    .pc_out        (pc_out),
    .bus           (bus),
    .busy          (busy),
    .pass          (pass),
    .fail          (fail),
    .fail_code     (fail_code),
    .match_cnt     (match_cnt),
    .mismatch_cnt  (mismatch_cnt),
    .first_err_a   (first_err_a),
    .first_err_d   (first_err_d),
    .first_err_exp (first_err_exp)
`ifdef WB_SCOREBOARD_SHADOW_EN
    , .shadow_regs (shadow_regs)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; pc_end = '0; pc_out = '0;
    bus.exp_valid = 1'b0; bus.exp_a = '0; bus.exp_d = '0;
    bus.wb_e = 1'b0; bus.wb_a = '0; bus.wb_d = '0;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic push(input logic [4:0] a, input logic [31:0] d);
    bus.exp_valid = 1'b1; bus.exp_a = a; bus.exp_d = d;
    tick();
    bus.exp_valid = 1'b0;
  endtask

  task automatic wb(input logic [4:0] a, input logic [31:0] d);
    bus.wb_e = 1'b1; bus.wb_a = a; bus.wb_d = d;
    tick();
    bus.wb_e = 1'b0;
  endtask

  task automatic do_start(input logic [31:0] pe);
    pc_end = pe; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 20 && !(pass || fail); i++) tick();
  endtask

  function automatic logic [4:0] ent_a(input int i);
    return 5'((i % 31) + 1);
  endfunction

  function automatic logic [31:0] ent_d(input int i);
    return 32'hA000_0000 + 32'(i);
  endfunction

  task automatic test_reset();
    do_reset();
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", busy); end
    vectors++; if ({pass, fail} !== 2'b00) begin miscompares++; $display("FAIL reset_passfail got %b want 00", {pass, fail}); end
    vectors++; if (bus.exp_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready got %b want 1", bus.exp_ready); end
    vectors++; if ({match_cnt, mismatch_cnt} !== 32'h0) begin miscompares++; $display("FAIL reset_cnts got %h want 0", {match_cnt, mismatch_cnt}); end
    vectors++; if ({fail_code, first_err_a, first_err_d, first_err_exp} !== '0) begin miscompares++; $display("FAIL reset_capture got nonzero code=%0d a=%0d", fail_code, first_err_a); end
  endtask

  task automatic test_match();
    do_reset();
    push(5'd1, 32'hDEADBEEF);
    push(5'd2, 32'h12345678);
    push(5'd7, 32'h0000_0004);
    do_start(32'd52);
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL match_busy got %b want 1", busy); end
    wb(5'd1, 32'hDEADBEEF);
    wb(5'd2, 32'h12345678);
    wb(5'd7, 32'h0000_0004);
    vectors++; if (match_cnt !== 16'd3) begin miscompares++; $display("FAIL match_cnt_run got %0d want 3", match_cnt); end
    pc_out = 32'd52;
    wait_done();
    vectors++; if ({pass, fail} !== 2'b10) begin miscompares++; $display("FAIL match_pass got pass=%b fail=%b want 1/0", pass, fail); end
    vectors++; if (mismatch_cnt !== 16'd0) begin miscompares++; $display("FAIL match_mismatch got %0d want 0", mismatch_cnt); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL match_busy_end got %b want 0", busy); end
`ifdef WB_SCOREBOARD_SHADOW_EN
    vectors++; if (shadow_regs[7] !== 32'h4) begin miscompares++; $display("FAIL shadow_r7 got %h want 4", shadow_regs[7]); end
    vectors++; if (shadow_regs[0] !== 32'h0) begin miscompares++; $display("FAIL shadow_r0 got %h want 0", shadow_regs[0]); end
`endif
  endtask

  task automatic test_mismatch();
    do_reset();
    pc_out = 32'd0;
    push(5'd3, 32'hFEDCBA98);
    do_start(32'd100);
    wb(5'd3, 32'hFEDCBA99);
    vectors++; if (fail !== 1'b1) begin miscompares++; $display("FAIL mm_fail got %b want 1", fail); end
    vectors++; if (fail_code !== 2'd1) begin miscompares++; $display("FAIL mm_code got %0d want 1", fail_code); end
    vectors++; if (first_err_a !== 5'd3) begin miscompares++; $display("FAIL mm_err_a got %0d want 3", first_err_a); end
    vectors++; if (first_err_d !== 32'hFEDCBA99) begin miscompares++; $display("FAIL mm_err_d got %h want FEDCBA99", first_err_d); end
    vectors++; if (first_err_exp !== 32'hFEDCBA98) begin miscompares++; $display("FAIL mm_err_exp got %h want FEDCBA98", first_err_exp); end
    wb(5'd3, 32'h1);  // ignored in terminal state
    vectors++; if (mismatch_cnt !== 16'd1) begin miscompares++; $display("FAIL mm_cnt got %0d want 1", mismatch_cnt); end
  endtask

  task automatic test_unexpected();
    do_reset();
    pc_out = 32'd0;
    do_start(32'd100);
    wb(5'd0, 32'd5);
    vectors++; if ({fail, mismatch_cnt} !== 17'd0) begin miscompares++; $display("FAIL x0_ignored got fail=%b mm=%0d want 0/0", fail, mismatch_cnt); end
    wb(5'd4, 32'd1);
    vectors++; if (fail !== 1'b1) begin miscompares++; $display("FAIL unexp_fail got %b want 1", fail); end
    vectors++; if (fail_code !== 2'd2) begin miscompares++; $display("FAIL unexp_code got %0d want 2", fail_code); end
    vectors++; if ({first_err_a, first_err_d} !== {5'd4, 32'd1}) begin miscompares++; $display("FAIL unexp_cap got a=%0d d=%h want 4/1", first_err_a, first_err_d); end
    vectors++; if (first_err_exp !== 32'd0) begin miscompares++; $display("FAIL unexp_exp got %h want 0", first_err_exp); end
  endtask

  task automatic test_back_to_back();
    // Push and writeback together on an empty FIFO: no bypass.
    do_reset();
    pc_out = 32'd0;
    do_start(32'd100);
    bus.exp_valid = 1'b1; bus.exp_a = 5'd5; bus.exp_d = 32'd7;
    bus.wb_e = 1'b1; bus.wb_a = 5'd5; bus.wb_d = 32'd7;
    tick();
    bus.exp_valid = 1'b0; bus.wb_e = 1'b0;
    vectors++; if ({fail, fail_code} !== 3'b110) begin miscompares++; $display("FAIL nobypass got fail=%b code=%0d want 1/2", fail, fail_code); end
    vectors++; if (match_cnt !== 16'd0) begin miscompares++; $display("FAIL nobypass_match got %0d want 0", match_cnt); end
  endtask

  task automatic test_timeout();
    do_reset();
    pc_out = 32'd0;
    do_start(32'd100);
    repeat (63) tick();
    vectors++; if (fail !== 1'b0) begin miscompares++; $display("FAIL to_early got %b want 0", fail); end
    tick();
    vectors++; if (fail !== 1'b1) begin miscompares++; $display("FAIL to_fail got %b want 1", fail); end
    vectors++; if (fail_code !== 2'd3) begin miscompares++; $display("FAIL to_code got %0d want 3", fail_code); end
  endtask

  task automatic test_full_wrap();
    int np, occ;
    logic acc, pushed;
    do_reset();
    pc_out = 32'd0;
    np = 0;
    bus.exp_valid = 1'b1; bus.exp_a = ent_a(np); bus.exp_d = ent_d(np);
    for (int c = 0; c < 18; c++) begin
      acc = bus.exp_ready;
      tick();
      if (acc) np++;
      bus.exp_a = ent_a(np); bus.exp_d = ent_d(np);
    end
    vectors++; if (np !== 16) begin miscompares++; $display("FAIL fill_count got %0d want 16", np); end
    vectors++; if (bus.exp_ready !== 1'b0) begin miscompares++; $display("FAIL full_ready got %b want 0", bus.exp_ready); end
    do_start(32'd200);
    occ = 16;
    for (int k = 0; k < 20; k++) begin
      vectors++; if (bus.exp_ready !== (occ < 16)) begin miscompares++; $display("FAIL wrap_ready k=%0d got %b want %b", k, bus.exp_ready, occ < 16); end
      pushed = (np < 20) && (occ < 16);
      bus.wb_e = 1'b1; bus.wb_a = ent_a(k); bus.wb_d = ent_d(k);
      tick();
      if (pushed) np++;
      occ = occ + (pushed ? 1 : 0) - 1;
      bus.exp_valid = (np < 20); bus.exp_a = ent_a(np); bus.exp_d = ent_d(np);
    end
    bus.wb_e = 1'b0; bus.exp_valid = 1'b0;
    pc_out = 32'd200;
    wait_done();
    vectors++; if (match_cnt !== 16'd20) begin miscompares++; $display("FAIL wrap_match got %0d want 20", match_cnt); end
    vectors++; if ({pass, mismatch_cnt} !== 17'h10000) begin miscompares++; $display("FAIL wrap_pass got pass=%b mm=%0d want 1/0", pass, mismatch_cnt); end
  endtask

  task automatic test_reset_midrun();
    do_reset();
    pc_out = 32'd0;
    for (int i = 1; i <= 5; i++) push(5'(i), 32'(i));
    do_start(32'd100);
    wb(5'd1, 32'd1);
    vectors++; if ({busy, match_cnt} !== {1'b1, 16'd1}) begin miscompares++; $display("FAIL mid_pre got busy=%b match=%0d want 1/1", busy, match_cnt); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    vectors++; if ({busy, pass, fail} !== 3'b000) begin miscompares++; $display("FAIL mid_state got %b want 000", {busy, pass, fail}); end
    vectors++; if (bus.exp_ready !== 1'b1) begin miscompares++; $display("FAIL mid_ready got %b want 1", bus.exp_ready); end
    vectors++; if ({match_cnt, mismatch_cnt} !== 32'h0) begin miscompares++; $display("FAIL mid_cnts got %h want 0", {match_cnt, mismatch_cnt}); end
    do_start(32'd100);
    wb(5'd2, 32'd2);  // old entry (2,2) must be gone
    vectors++; if ({fail, fail_code} !== 3'b110) begin miscompares++; $display("FAIL mid_discard got fail=%b code=%0d want 1/2", fail, fail_code); end
  endtask

  initial begin
    test_reset();
    test_match();
    test_mismatch();
    test_unexpected();
    test_back_to_back();
    test_timeout();
    test_full_wrap();
    test_reset_midrun();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
